// File: rtl/bus_router_pkg.sv
// Shared types and width helpers for the master-to-slave router.
package bus_router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONNECT = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   localparam int TIMEOUT_CYC_DEF = 256;

   // Number of per-channel serial signals carried through the router
   localparam int BUS_W = 7;

   // Slave select is binary with 0 reserved for "no slave"
   function automatic int ssel_w(input int num_slaves);
      return $clog2(num_slaves + 1);
   endfunction

   // Master index needs at least one bit even for two masters
   function automatic int midx_w(input int num_masters);
      return (num_masters > 2) ? $clog2(num_masters) : 1;
   endfunction

   // Idle counter width; a disabled timeout still keeps a 1-bit counter
   function automatic int cnt_w(input int timeout_cyc);
      return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
   endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Converts a grant vector to a binary index and flags exactly-one-hot input.
module onehot_to_idx #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_is_onehot
);

   // OR together the indices of all set bits; only meaningful when one-hot
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (i_vec[i]) o_idx = o_idx | W'(i);
      end
   end

   assign o_is_onehot = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);

endmodule

// File: rtl/master_router.sv
// Routes one granted master's serial bus onto one selected slave channel,
// with registered outputs, release on grant drop and an idle timeout.
module master_router
   import bus_router_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   parameter  int NUM_SLAVES  = 3,
   parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   localparam int SSEL_W      = ssel_w(NUM_SLAVES),
   localparam int MIDX_W      = midx_w(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] bus_grant,
   input  logic [SSEL_W-1:0]      slave_sel,
   input  logic [NUM_MASTERS-1:0] m_master_ready,
   input  logic [NUM_MASTERS-1:0] m_master_valid,
   input  logic [NUM_MASTERS-1:0] m_read_en,
   input  logic [NUM_MASTERS-1:0] m_write_en,
   input  logic [NUM_MASTERS-1:0] m_tx_address,
   input  logic [NUM_MASTERS-1:0] m_tx_data,
   input  logic [NUM_MASTERS-1:0] m_tx_burst,
   output logic [NUM_SLAVES-1:0]  s_master_ready,
   output logic [NUM_SLAVES-1:0]  s_master_valid,
   output logic [NUM_SLAVES-1:0]  s_read_en,
   output logic [NUM_SLAVES-1:0]  s_write_en,
   output logic [NUM_SLAVES-1:0]  s_tx_address,
   output logic [NUM_SLAVES-1:0]  s_tx_data,
   output logic [NUM_SLAVES-1:0]  s_tx_burst,
   output logic                   route_active,
   output logic [MIDX_W-1:0]      route_master,
   output logic [SSEL_W-1:0]      route_slave,
   output logic                   timeout_pulse,
   output logic                   decode_err
);

   localparam int CNT_W = cnt_w(TIMEOUT_CYC);
   // Bundle bit positions: {ready, valid, read, write, addr, data, burst}
   localparam int B_VALID = 5;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_SAT =
      (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC) : {CNT_W{1'b1}};

   logic [BUS_W-1:0]                  w_mbus [NUM_MASTERS];
   logic [BUS_W-1:0]                  w_gbus;
   logic [BUS_W-1:0]                  w_lbus;
   logic                              w_lgrant;
   logic [MIDX_W-1:0]                 w_gidx;
   logic                              w_onehot;
   logic                              w_sel_ok;

   state_t                            r_state, w_state_next;
   logic [MIDX_W-1:0]                 r_midx, w_midx_next;
   logic [SSEL_W-1:0]                 r_slave, w_slave_next;
   logic [CNT_W-1:0]                  r_cnt, w_cnt_next;
   logic [NUM_SLAVES-1:0][BUS_W-1:0]  r_sbus, w_sbus_next;
   logic                              r_tpulse, w_tpulse_next;
   logic                              r_derr, w_derr_next;

   genvar gi;

   // Pack each master's serial signals into one bundle
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mbus
         assign w_mbus[gi] = {m_master_ready[gi], m_master_valid[gi], m_read_en[gi],
                              m_write_en[gi], m_tx_address[gi], m_tx_data[gi],
                              m_tx_burst[gi]};
      end
   endgenerate

   onehot_to_idx #(
      .N (NUM_MASTERS),
      .W (MIDX_W)
   ) u_grant_idx (
      .i_vec       (bus_grant),
      .o_idx       (w_gidx),
      .o_is_onehot (w_onehot)
   );

   assign w_sel_ok = (slave_sel != '0) && (slave_sel <= SSEL_W'(NUM_SLAVES));

   // Select the newly granted master's bundle and the latched master's bundle/grant
   always_comb begin
      w_gbus   = '0;
      w_lbus   = '0;
      w_lgrant = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_gidx == MIDX_W'(i)) w_gbus = w_mbus[i];
         if (r_midx == MIDX_W'(i)) begin
            w_lbus   = w_mbus[i];
            w_lgrant = bus_grant[i];
         end
      end
   end

   // Next-state and output-register logic; s_* default to 0 every cycle
   always_comb begin
      w_state_next  = r_state;
      w_midx_next   = r_midx;
      w_slave_next  = r_slave;
      w_cnt_next    = r_cnt;
      w_sbus_next   = '0;
      w_tpulse_next = 1'b0;
      w_derr_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus_grant != '0) begin
               if (w_onehot && w_sel_ok) begin
                  w_state_next = ST_CONNECT;
                  w_midx_next  = w_gidx;
                  w_slave_next = slave_sel;
                  w_cnt_next   = '0;
                  for (int j = 0; j < NUM_SLAVES; j++) begin
                     if (slave_sel == SSEL_W'(j + 1)) w_sbus_next[j] = w_gbus;
                  end
               end else begin
                  w_derr_next = 1'b1;
               end
            end
         end
         ST_CONNECT: begin
            // Grant drop wins over a timeout landing on the same edge
            if (!w_lgrant) begin
               w_state_next = ST_IDLE;
            end else if ((TIMEOUT_CYC > 0) && !w_lbus[B_VALID] && (r_cnt == CNT_LAST)) begin
               w_state_next  = ST_HOLDOFF;
               w_tpulse_next = 1'b1;
               w_cnt_next    = '0;
            end else begin
               if (w_lbus[B_VALID]) w_cnt_next = '0;
               else if (r_cnt != CNT_SAT) w_cnt_next = r_cnt + CNT_W'(1);
               for (int j = 0; j < NUM_SLAVES; j++) begin
                  if (r_slave == SSEL_W'(j + 1)) w_sbus_next[j] = w_lbus;
               end
            end
         end
         ST_HOLDOFF: begin
            if (!w_lgrant) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= ST_IDLE;
         r_midx   <= '0;
         r_slave  <= '0;
         r_cnt    <= '0;
         r_sbus   <= '0;
         r_tpulse <= 1'b0;
         r_derr   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_midx   <= w_midx_next;
         r_slave  <= w_slave_next;
         r_cnt    <= w_cnt_next;
         r_sbus   <= w_sbus_next;
         r_tpulse <= w_tpulse_next;
         r_derr   <= w_derr_next;
      end
   end

   // Unpack slave bundles onto the per-signal output ports
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sbus
         assign s_master_ready[gi] = r_sbus[gi][6];
         assign s_master_valid[gi] = r_sbus[gi][5];
         assign s_read_en[gi]      = r_sbus[gi][4];
         assign s_write_en[gi]     = r_sbus[gi][3];
         assign s_tx_address[gi]   = r_sbus[gi][2];
         assign s_tx_data[gi]      = r_sbus[gi][1];
         assign s_tx_burst[gi]     = r_sbus[gi][0];
      end
   endgenerate

   assign route_active  = (r_state == ST_CONNECT);
   assign route_master  = route_active ? r_midx : '0;
   assign route_slave   = route_active ? r_slave : '0;
   assign timeout_pulse = r_tpulse;
   assign decode_err    = r_derr;

endmodule

// File: doc/master_router.md
MASTER_ROUTER -- requirements
Module: master_router

Interface
REQ-001 SHALL provide parameter NUM_MASTERS, default 2: number of master channels (2..8).
REQ-002 SHALL provide parameter NUM_SLAVES, default 3: number of slave channels (1..7).
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 256: maximum consecutive idle-valid cycles allowed on a live route; 0 disables the timeout.
REQ-004 SHALL define the port list below; SSEL_W = clog2(NUM_SLAVES+1) and MIDX_W = max(1, clog2(NUM_MASTERS)).
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- bus_grant  in  NUM_MASTERS  one-hot grant from the arbiter; bit i = master i.
- slave_sel  in  SSEL_W  binary slave number; 1..NUM_SLAVES valid, 0 = none.
- m_master_ready, m_master_valid, m_read_en, m_write_en, m_tx_address, m_tx_data, m_tx_burst  in  NUM_MASTERS each  per-master serial bus signals, bit i = master i.
- s_master_ready, s_master_valid, s_read_en, s_write_en, s_tx_address, s_tx_data, s_tx_burst  out  NUM_SLAVES each  per-slave forwarded signals, bit j = slave j+1.
- route_active  out  1  high while a route is live.
- route_master  out  MIDX_W  index of the latched master.
- route_slave  out  SSEL_W  latched slave number; 0 when idle.
- timeout_pulse  out  1  one-cycle pulse when a route is force-released.
- decode_err  out  1  high for each cycle an illegal grant or slave_sel is seen in IDLE.

Function
REQ-005 SHALL implement an FSM with states IDLE, CONNECT and HOLDOFF.
REQ-006 IDLE: if bus_grant is exactly one-hot and slave_sel is in 1..NUM_SLAVES, SHALL latch the master index and slave number, load the output registers and enter CONNECT at that edge.
REQ-007 IDLE: if bus_grant is nonzero but not one-hot, or bus_grant is one-hot but slave_sel is out of range, SHALL assert decode_err, make no route and stay in IDLE.
REQ-008 All s_* outputs SHALL be registered; the latched master's inputs at cycle k appear on the latched slave's outputs at cycle k+1, including the accepting cycle.
REQ-009 All non-selected slave outputs SHALL be driven 0 at all times, and all s_* outputs SHALL be 0 outside CONNECT.
REQ-010 CONNECT: changes on slave_sel and on other masters' grant bits SHALL be ignored.
REQ-011 CONNECT: when the latched master's bus_grant bit is 0, SHALL clear all s_* registers and return to IDLE at that edge; a new grant is accepted no earlier than the following cycle.
REQ-012 CONNECT: the idle counter SHALL increment each cycle the latched m_master_valid is 0, and SHALL clear when that valid is 1 or on entry to CONNECT.
REQ-013 When TIMEOUT_CYC>0 and the idle counter reaches TIMEOUT_CYC, SHALL clear the s_* outputs, pulse timeout_pulse for one cycle and enter HOLDOFF.
REQ-014 Release in REQ-011 SHALL take priority over timeout in the same cycle, with no timeout_pulse.
REQ-015 HOLDOFF: SHALL keep outputs 0 and return to IDLE only after the latched master's grant bit is 0.
REQ-016 The idle counter SHALL saturate and never wrap; its width SHALL be clog2(TIMEOUT_CYC+1).
REQ-017 route_active SHALL be 1 only in CONNECT; route_master and route_slave SHALL reflect the latched values in CONNECT and be 0 otherwise.

Reset
REQ-018 While rstn is low, SHALL force state IDLE, all s_* outputs 0, route_active 0, route_master 0, route_slave 0, timeout_pulse 0, decode_err 0 and the counter 0, asynchronously.
REQ-019 Reset asserted mid-CONNECT SHALL drop all outputs immediately, without waiting for a clock edge.

Structure
REQ-020 Package bus_router_pkg SHALL hold the state enum, the TIMEOUT_CYC default and the SSEL_W/MIDX_W width functions.
REQ-021 SHALL instantiate one sub-module, onehot_to_idx, which returns the index plus an is_onehot flag.

Verification
REQ-022 NM=2, NS=3: bus_grant=01, slave_sel=2, m_tx_data[0] toggling -> s_tx_data[1] follows one cycle later, all other s_* bits 0, route_slave=2.
REQ-023 bus_grant=11 in IDLE -> decode_err=1 and no s_* activity; bus_grant=10 with slave_sel=0 -> decode_err=1.
REQ-024 Live route to master 1; bus_grant goes 10->01 in one cycle -> outputs clear at the next edge and master 0 is routed one cycle after that.
REQ-025 TIMEOUT_CYC=4, latched valid held 0 -> timeout_pulse on the 4th idle cycle, HOLDOFF until the grant drops, then IDLE.
REQ-026 rstn pulsed low mid-burst -> all outputs 0 asynchronously; after release, state is IDLE with route_slave=0.
